// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO read-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/fifo_read_arbiter_rr_arbiter.sv
// Rotating-priority encoder: index of the first asserted request at or after rr_ptr.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [IW-1:0] cand;

    // Walk from the farthest offset down so the nearest request wins.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IW'((int'(rr_ptr) + k) % NREQ);
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Round-robin, burst-bounded arbiter that owns the read strobe of an async FIFO.
// state | meaning: IDLE arbitrate | BURST granted consumer reads | GAP one dead cycle between grants
module fifo_read_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DSIZE     = 8,
    parameter int MAX_BURST = 16,
    parameter int LOW_BURST = 1,
    localparam int IW       = idx_width(NREQ)
) (
    input  logic             r_clk,
    input  logic             r_rst,
    input  logic [NREQ-1:0]  req,
    input  logic             rempty,
    input  logic             hempty,
    input  logic [DSIZE-1:0] fifo_rdata,
    output logic             r_inc,
    output logic [NREQ-1:0]  gnt,
    output logic             rd_valid,
    output logic [DSIZE-1:0] rd_data,
    output logic [IW-1:0]    rd_id
);

    localparam int CW = cnt_width(MAX_BURST);
    localparam logic [CW-1:0] MAX_L = CW'(MAX_BURST);
    localparam logic [CW-1:0] LOW_L = CW'(LOW_BURST);

    arb_state_t    state, state_nxt;
    logic [IW-1:0] rr_ptr;
    logic [CW-1:0] burst_cnt;
    logic [CW-1:0] limit;
    logic [IW-1:0] arb_idx;
    logic          arb_any;
    logic          start;
    logic          burst_end;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req    (req),
        .rr_ptr (rr_ptr),
        .idx    (arb_idx),
        .any    (arb_any)
    );

    assign start     = (state == IDLE) && arb_any && !rempty;
    assign burst_end = (state == BURST) &&
                       ((r_inc && (burst_cnt == limit - CW'(1))) || !req[rd_id] || rempty);

    always_ff @(posedge r_clk) begin
        if (r_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = BURST;
            BURST:   if (burst_end) state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        r_inc = 1'b0;
        if (state == BURST) r_inc = req[rd_id] && !rempty;
    end

    assign rd_valid = r_inc;
    assign rd_data  = fifo_rdata;

    // Burst limit is latched at grant so hempty changes mid-burst are ignored.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            gnt       <= '0;
            rd_id     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            limit     <= MAX_L;
        end else if (start) begin
            gnt       <= NREQ'(1) << arb_idx;
            rd_id     <= arb_idx;
            limit     <= hempty ? LOW_L : MAX_L;
            burst_cnt <= '0;
        end else if (burst_end) begin
            gnt    <= '0;
            rr_ptr <= (rd_id == IW'(NREQ - 1)) ? '0 : rd_id + 1'b1;
        end else if (r_inc) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

    a_gnt_onehot: assert property (@(posedge r_clk) disable iff (r_rst) $onehot0(gnt));
    a_no_empty_read: assert property (@(posedge r_clk) disable iff (r_rst) r_inc |-> !rempty);
    a_granted_read: assert property (@(posedge r_clk) disable iff (r_rst)
                                     r_inc |-> (gnt[rd_id] && req[rd_id]));

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Bench for fifo_read_arbiter: FIFO model plus a scoreboard of expected reads (id, data, idle gap).
module tb_fifo_read_arbiter;

    logic       r_clk = 1'b0;
    logic       r_rst = 1'b1;
    logic [3:0] req = '0;
    logic       rempty = 1'b1;
    logic       hempty = 1'b0;
    logic [7:0] fifo_rdata = '0;
    logic       r_inc;
    logic [3:0] gnt;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [1:0] rd_id;

    fifo_read_arbiter #(.NREQ(4), .DSIZE(8), .MAX_BURST(16), .LOW_BURST(1)) dut (
        .r_clk      (r_clk),
        .r_rst      (r_rst),
        .req        (req),
        .rempty     (rempty),
        .hempty     (hempty),
        .fifo_rdata (fifo_rdata),
        .r_inc      (r_inc),
        .gnt        (gnt),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_id      (rd_id)
    );

    always #5 r_clk = ~r_clk;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
        int         gap;
    } exp_t;

    typedef struct {
        logic [3:0] req;
        bit         hempty;
        int         words;
        int         reads;
        int         burst;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];

    int         n_vec = 0;
    int         n_miss = 0;
    logic [3:0] cur_req;
    int         fifo_cnt;
    logic [7:0] fifo_data;
    logic [7:0] push_data;
    int         gap;
    int         nreads;
    int         ev_at;
    int         ev_kind;
    logic [3:0] ev_req;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int id, input int g);
        exp_t e;
        e.id   = 2'(id);
        e.data = push_data;
        e.gap  = g;
        push_data = push_data + 8'd1;
        sb.push_back(e);
    endtask

    // Expected round-robin schedule for a constant request pattern, starting from pointer 0.
    task automatic gen(input logic [3:0] r, input int burst, input int n);
        int ptr, done, j;
        bit first;
        ptr = 0; done = 0; first = 1'b1; j = 0;
        while (done < n) begin
            for (int k = 0; k < 4; k++) begin
                j = (ptr + k) % 4;
                if (r[j]) break;
            end
            for (int b = 0; b < burst && done < n; b++) begin
                push(j, (b != 0) ? 0 : (first ? 1 : 2));
                done++;
                first = 1'b0;
            end
            ptr = (j + 1) % 4;
        end
    endtask

    task automatic fill(input int words, input logic [7:0] seed);
        fifo_cnt  = words;
        fifo_data = seed;
        push_data = seed;
    endtask

    task automatic do_reset();
        r_rst = 1'b1; cur_req = '0; req = '0; hempty = 1'b0; rempty = 1'b1;
        fifo_cnt = 0; ev_kind = 0; sb.delete();
        repeat (2) @(negedge r_clk);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_id", rd_id, 0);
        r_rst = 1'b0;
        @(negedge r_clk);
        gap = 0; nreads = 0;
    endtask

    // One cycle: drive after the falling edge, check settled outputs, update the FIFO model.
    task automatic tick();
        exp_t e;
        req = cur_req; rempty = (fifo_cnt == 0); fifo_rdata = fifo_data;
        #1;
        if (rd_valid) begin
            chk("read_while_empty", rempty, 0);
            if (sb.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL unexpected_read: rd_id=%0d gnt=%b, required no read (t=%0t)", rd_id, gnt, $time);
            end else begin
                e = sb.pop_front();
                chk("rd_id", rd_id, e.id);
                chk("rd_data", rd_data, e.data);
                chk("gnt", gnt, 1 << e.id);
                chk("gap", gap, e.gap);
            end
            fifo_cnt--; fifo_data = fifo_data + 8'd1; nreads++; gap = 0;
            if (ev_kind != 0 && nreads == ev_at) begin
                case (ev_kind)
                    1: cur_req = ev_req;
                    2: hempty = 1'b1;
                    default: r_rst = 1'b1;
                endcase
                ev_kind = 0;
            end
        end else begin
            gap++;
        end
        @(negedge r_clk);
    endtask

    task automatic run_until_empty(input int max_cyc);
        int cyc;
        cyc = 0;
        while (sb.size() > 0 && cyc < max_cyc) begin
            tick();
            cyc++;
        end
        if (sb.size() > 0) begin
            n_vec++; n_miss++;
            $display("FAIL timeout: %0d reads still outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'b0001, 1'b0, 100, 32, 16};
        vecs[1] = '{4'b1111, 1'b0, 200, 80, 16};
        vecs[2] = '{4'b0101, 1'b1, 100, 6, 1};
        vecs[3] = '{4'b1010, 1'b1, 100, 4, 1};
        vecs[4] = '{4'b0110, 1'b0, 100, 40, 16};
        vecs[5] = '{4'b0001, 1'b0, 5, 5, 16};

        @(negedge r_clk);
        foreach (vecs[v]) begin
            do_reset();
            hempty = vecs[v].hempty;
            fill(vecs[v].words, 8'(v * 40));
            gen(vecs[v].req, vecs[v].burst, vecs[v].reads);
            cur_req = vecs[v].req;
            run_until_empty(600);
            if (vecs[v].words == vecs[v].reads) begin
                repeat (6) tick();
                chk("gnt_idle_when_empty", gnt, 0);
            end
        end

        // Consumer 3 drops its request after 4 reads; pointer moves on to 0.
        do_reset();
        fill(100, 8'hA0);
        cur_req = 4'b1000;
        ev_kind = 1; ev_at = 4; ev_req = 4'b0101;
        for (int i = 0; i < 4; i++) push(3, (i == 0) ? 1 : 0);
        for (int i = 0; i < 16; i++) push(0, (i == 0) ? 3 : 0);
        push(2, 2);
        run_until_empty(200);

        // hempty rising mid-burst leaves the current limit alone; later grants are single reads.
        do_reset();
        fill(100, 8'h10);
        cur_req = 4'b0001;
        ev_kind = 2; ev_at = 2;
        for (int i = 0; i < 16; i++) push(0, (i == 0) ? 1 : 0);
        for (int i = 0; i < 3; i++) push(0, 2);
        run_until_empty(200);

        // Reset on the 7th read of consumer 1's burst; afterwards consumer 0 must win again.
        do_reset();
        fill(100, 8'h60);
        cur_req = 4'b0011;
        ev_kind = 3; ev_at = 23;
        for (int i = 0; i < 16; i++) push(0, (i == 0) ? 1 : 0);
        for (int i = 0; i < 7; i++) push(1, (i == 0) ? 2 : 0);
        run_until_empty(200);
        req = cur_req; rempty = (fifo_cnt == 0); fifo_rdata = fifo_data;
        #1;
        chk("rst_mid_rinc", r_inc, 0);
        chk("rst_mid_gnt", gnt, 0);
        r_rst = 1'b0;
        gap = 1;
        @(negedge r_clk);
        push_data = fifo_data;
        for (int i = 0; i < 16; i++) push(0, (i == 0) ? 1 : 0);
        run_until_empty(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
